vlc_phase_tracker: RTL

//  Receiving end of the slice sequencer's dc_vlc_reset/ac_vlc_reset strobes. Detects the strobe

---
 rtl/vlc_phase_tracker_pkg.sv | 21 ++
 rtl/strobe_edge_det.sv | 23 ++
 rtl/vlc_phase_tracker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vlc_phase_tracker_pkg.sv
// Shared definitions for the VLC slice phase tracker: phase-state encoding,
// AC codewords per block and the block_num range check.
package vlc_phase_tracker_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_DC      = 3'd1,
    PH_WAIT_AC = 3'd2,
    PH_AC      = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  // AC coefficients per 8x8 block (DC coefficient excluded).
  localparam int AC_PER_BLOCK = 63;

  // A slice must carry at least one block and no more than max_blocks.
  function automatic logic block_num_ok(input logic [31:0] n, input int max_blocks);
    return (n != 32'd0) && (n <= 32'(max_blocks));
  endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Falling-edge detector for an idle-high sequencer strobe. The history
// register resets to 1 so a strobe already low out of reset reads as an edge.
module strobe_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic fall_edge
);

  logic prev_q;

  // Remember last cycle's strobe level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= strobe;
    end
  end

  assign fall_edge = prev_q & ~strobe;

endmodule

// File: rtl/vlc_phase_tracker.sv
// Slice DC/AC phase tracker. Turns the sequencer's dc/ac strobes into phase
// transitions, counts VLC codewords per phase, accumulates their bit lengths
// and reports slice completion or protocol violations to the packer.
module vlc_phase_tracker
  import vlc_phase_tracker_pkg::*;
#(
  parameter int MAX_BLOCKS = 8,
  parameter int LEN_W      = 5,
  parameter int BITS_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       block_num,
  input  logic              dc_vlc_reset,
  input  logic              ac_vlc_reset,
  input  logic              vlc_valid,
  input  logic [LEN_W-1:0]  vlc_len,
  output logic              dc_phase,
  output logic              ac_phase,
  output logic [31:0]       block_index,
  output logic [5:0]        coef_index,
  output logic [BITS_W-1:0] slice_bits,
  output logic              slice_done,
  output logic              proto_error
);

  // Internal counters only need to span the legal slice size.
  localparam int BLK_W = $clog2(MAX_BLOCKS + 1);
  localparam int CNT_W = $clog2(AC_PER_BLOCK * MAX_BLOCKS + 1);

  // ---------------------------------------------------------------------
  // Strobe edge detection: index 0 = DC strobe, index 1 = AC strobe
  // ---------------------------------------------------------------------
  logic [1:0] strobes;
  logic [1:0] edges;
  logic       dc_edge;
  logic       ac_edge;

  assign strobes = {ac_vlc_reset, dc_vlc_reset};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      strobe_edge_det u_edge (
        .clock     (clock),
        .reset     (reset),
        .strobe    (strobes[gi]),
        .fall_edge (edges[gi])
      );
    end
  endgenerate

  assign dc_edge = edges[0];
  assign ac_edge = edges[1];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  phase_e             state_q, state_d;
  logic [BLK_W-1:0]   bn_q, bn_d;        // block count latched on DC edge
  logic [BLK_W-1:0]   blk_q, blk_d;      // block index within current phase
  logic [5:0]         coef_q, coef_d;    // AC coefficient index 1..63
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // AC codewords accepted this slice
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic               err_q, err_d;

  logic               bn_ok;
  logic [CNT_W-1:0]   ac_target;
  logic [BITS_W:0]    bits_sum;
  logic [BITS_W-1:0]  bits_sat;
  logic               err_set;
  logic               start_slice;

  assign bn_ok     = block_num_ok(block_num, MAX_BLOCKS);
  assign ac_target = CNT_W'(bn_q) * CNT_W'(AC_PER_BLOCK);

  // One extra carry bit tells us the accumulator would overflow; clamp then.
  assign bits_sum = {1'b0, bits_q} + {{(BITS_W + 1 - LEN_W){1'b0}}, vlc_len};
  assign bits_sat = bits_sum[BITS_W] ? {BITS_W{1'b1}} : bits_sum[BITS_W-1:0];

  // Next-state logic: a DC edge outranks everything else in the cycle; errors
  // raised in the cycle are applied after any clear so they always stick.
  always_comb begin
    state_d     = state_q;
    bn_d        = bn_q;
    blk_d       = blk_q;
    coef_d      = coef_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    err_d       = err_q;
    err_set     = 1'b0;
    start_slice = 1'b0;

    if (dc_edge) begin
      if (state_q == PH_IDLE || state_q == PH_DONE) begin
        // A simultaneous AC edge or a stray codeword is still a violation.
        if (ac_edge || vlc_valid) err_set = 1'b1;
        if (bn_ok) begin
          err_d       = 1'b0;
          start_slice = 1'b1;
        end else begin
          err_set = 1'b1;
          state_d = PH_IDLE;
        end
      end else begin
        // DC edge mid-slice: flag it and restart with a fresh latch.
        err_set = 1'b1;
        if (bn_ok) start_slice = 1'b1;
        else       state_d     = PH_IDLE;
      end

      if (start_slice) begin
        state_d = PH_DC;
        bn_d    = block_num[BLK_W-1:0];
        blk_d   = '0;
        coef_d  = '0;
        cnt_d   = '0;
        bits_d  = '0;
      end
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (ac_edge || vlc_valid) err_set = 1'b1;
        end

        PH_DC: begin
          if (ac_edge) err_set = 1'b1;
          if (vlc_valid) begin
            bits_d = bits_sat;
            if (blk_q == bn_q - 1'b1) begin
              state_d = PH_WAIT_AC;
              blk_d   = '0;
            end else begin
              blk_d = blk_q + 1'b1;
            end
          end
        end

        PH_WAIT_AC: begin
          if (vlc_valid) err_set = 1'b1;
          if (ac_edge) begin
            state_d = PH_AC;
            blk_d   = '0;
            coef_d  = 6'd1;
            cnt_d   = '0;
          end
        end

        PH_AC: begin
          // Codeword is accounted before the closing edge is judged.
          if (vlc_valid) begin
            if (cnt_q != ac_target) begin
              bits_d = bits_sat;
              cnt_d  = cnt_q + 1'b1;
              // Indices freeze on the final codeword instead of wrapping past the slice.
              if ((cnt_q + 1'b1) != ac_target) begin
                if (coef_q == 6'(AC_PER_BLOCK)) begin
                  coef_d = 6'd1;
                  blk_d  = blk_q + 1'b1;
                end else begin
                  coef_d = coef_q + 1'b1;
                end
              end
            end else begin
              err_set = 1'b1;
            end
          end
          if (ac_edge) begin
            if (cnt_d == ac_target) begin
              state_d = PH_DONE;
            end else begin
              err_set = 1'b1;
              state_d = PH_IDLE;
            end
          end
        end

        PH_DONE: begin
          if (ac_edge || vlc_valid) err_set = 1'b1;
          state_d = PH_IDLE;
        end

        default: begin
          state_d = PH_IDLE;
        end
      endcase
    end

    if (err_set) err_d = 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PH_IDLE;
      bn_q    <= '0;
      blk_q   <= '0;
      coef_q  <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bn_q    <= bn_d;
      blk_q   <= blk_d;
      coef_q  <= coef_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: indices only mean something while a counting phase is active.
  // ---------------------------------------------------------------------
  assign dc_phase    = (state_q == PH_DC);
  assign ac_phase    = (state_q == PH_AC);
  assign slice_done  = (state_q == PH_DONE);
  assign block_index = (dc_phase || ac_phase) ? {{(32 - BLK_W){1'b0}}, blk_q} : 32'd0;
  assign coef_index  = ac_phase ? coef_q : 6'd0;
  assign slice_bits  = bits_q;
  assign proto_error = err_q;

endmodule
